if_fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline latch. Holds the PC, drives the

---
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues the instruction read and predicts
// the next PC through a direct-mapped BTB of 2-bit saturating counters trained by EX.
module if_fetch_unit #(
   parameter int unsigned          WORD_SIZE      = 16,
   parameter int unsigned          BTB_INDEX_BITS = 4,
   parameter logic [WORD_SIZE-1:0] RESET_PC       = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic                 i_ready,
   input  logic                 stall_IF,
   input  logic                 redirect_EX,
   input  logic [WORD_SIZE-1:0] redirect_pc_EX,
   input  logic                 btb_update_EX,
   input  logic [WORD_SIZE-1:0] btb_update_pc_EX,
   input  logic [WORD_SIZE-1:0] btb_update_target_EX,
   input  logic                 btb_update_taken_EX,
   output logic [WORD_SIZE-1:0] pc_IF,
   output logic [WORD_SIZE-1:0] branch_predicted_pc_IF,
   output logic [WORD_SIZE-1:0] instruction_IF,
   output logic                 tag_match_IF
);

   localparam int unsigned BTB_ENTRIES  = 1 << BTB_INDEX_BITS;
   localparam int unsigned TAG_BITS     = WORD_SIZE - BTB_INDEX_BITS;
   localparam int unsigned OPERAND_BITS = WORD_SIZE - 4;
   localparam logic [3:0]  OPCODE_NOP   = 4'hF;
   localparam logic [WORD_SIZE-1:0] NOP_WORD = {OPCODE_NOP, OPERAND_BITS'(0)};

   logic [WORD_SIZE-1:0] pc;

   logic                 btb_valid  [BTB_ENTRIES];
   logic [TAG_BITS-1:0]  btb_tag    [BTB_ENTRIES];
   logic [WORD_SIZE-1:0] btb_target [BTB_ENTRIES];
   logic [1:0]           btb_ctr    [BTB_ENTRIES];

   logic [BTB_INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]       lk_tag;
   logic                      lk_hit;
   logic [WORD_SIZE-1:0]      lk_pred;

   logic [BTB_INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]       upd_tag;
   logic                      upd_hit;

   // BTB read port: lookup for the current PC using pre-edge contents
   always_comb begin
      lk_idx  = pc[BTB_INDEX_BITS-1:0];
      lk_tag  = pc[WORD_SIZE-1:BTB_INDEX_BITS];
      lk_hit  = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
      lk_pred = (lk_hit && btb_ctr[lk_idx][1]) ? btb_target[lk_idx]
                                               : pc + WORD_SIZE'(1);
   end

   // Fetch outputs; a bubble is presented while in reset or while memory is not ready
   always_comb begin
      i_readM                = reset_n;
      i_address              = pc;
      pc_IF                  = pc;
      instruction_IF         = i_data;
      tag_match_IF           = lk_hit;
      branch_predicted_pc_IF = lk_pred;
      if (!reset_n) begin
         instruction_IF         = NOP_WORD;
         tag_match_IF           = 1'b0;
         branch_predicted_pc_IF = RESET_PC + WORD_SIZE'(1);
      end else if (!i_ready) begin
         instruction_IF         = NOP_WORD;
         tag_match_IF           = 1'b0;
         branch_predicted_pc_IF = pc;
      end
   end

   // PC: EX redirect beats stall and memory wait
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc <= RESET_PC;
      end else if (redirect_EX) begin
         pc <= redirect_pc_EX;
      end else if (!stall_IF && i_ready) begin
         pc <= branch_predicted_pc_IF;
      end
   end

   always_comb begin
      upd_idx = btb_update_pc_EX[BTB_INDEX_BITS-1:0];
      upd_tag = btb_update_pc_EX[WORD_SIZE-1:BTB_INDEX_BITS];
      upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
   end

   // BTB write port: train a resident entry or allocate over whatever is there
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[BTB_INDEX_BITS'(i)]  <= 1'b0;
            btb_tag[BTB_INDEX_BITS'(i)]    <= '0;
            btb_target[BTB_INDEX_BITS'(i)] <= '0;
            btb_ctr[BTB_INDEX_BITS'(i)]    <= 2'b01;
         end
      end else if (btb_update_EX) begin
         if (upd_hit) begin
            if (btb_update_taken_EX) begin
               btb_target[upd_idx] <= btb_update_target_EX;
               if (btb_ctr[upd_idx] != 2'b11) btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
            end else if (btb_ctr[upd_idx] != 2'b00) begin
               btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
            end
         end else begin
            btb_valid[upd_idx]  <= 1'b1;
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= btb_update_target_EX;
            btb_ctr[upd_idx]    <= btb_update_taken_EX ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: scenario tasks push expected fetch-stage observations to a
// scoreboard queue and pop them when the combinational outputs are sampled mid-cycle.
module tb_if_fetch_unit;

   typedef logic [65:0] obs_t;
   localparam logic [15:0] NOP = 16'hF000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_readM;
   logic [15:0] i_address;
   logic [15:0] i_data;
   logic        i_ready;
   logic        stall_IF;
   logic        redirect_EX;
   logic [15:0] redirect_pc_EX;
   logic        btb_update_EX;
   logic [15:0] btb_update_pc_EX;
   logic [15:0] btb_update_target_EX;
   logic        btb_update_taken_EX;
   logic [15:0] pc_IF;
   logic [15:0] branch_predicted_pc_IF;
   logic [15:0] instruction_IF;
   logic        tag_match_IF;

   obs_t obs;
   obs_t e;
   obs_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   if_fetch_unit dut (
      .clk(clk), .reset_n(reset_n), .i_readM(i_readM), .i_address(i_address),
      .i_data(i_data), .i_ready(i_ready), .stall_IF(stall_IF), .redirect_EX(redirect_EX),
      .redirect_pc_EX(redirect_pc_EX), .btb_update_EX(btb_update_EX),
      .btb_update_pc_EX(btb_update_pc_EX), .btb_update_target_EX(btb_update_target_EX),
      .btb_update_taken_EX(btb_update_taken_EX), .pc_IF(pc_IF),
      .branch_predicted_pc_IF(branch_predicted_pc_IF), .instruction_IF(instruction_IF),
      .tag_match_IF(tag_match_IF)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   // Instruction memory model
   assign i_data = mem(i_address);
   assign obs = {i_readM, tag_match_IF, pc_IF, branch_predicted_pc_IF, instruction_IF, i_address};

   function automatic obs_t pack(input logic rd, input logic tg, input logic [15:0] pc,
                                 input logic [15:0] pred, input logic [15:0] ins);
      return {rd, tg, pc, pred, ins, pc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [15:0] p);
      redirect_EX = 1'b1; redirect_pc_EX = p;
      tick();
      redirect_EX = 1'b0;
   endtask

   task automatic train(input logic [15:0] p, input logic [15:0] t, input logic tk);
      btb_update_EX = 1'b1; btb_update_pc_EX = p; btb_update_target_EX = t;
      btb_update_taken_EX = tk;
      tick();
      btb_update_EX = 1'b0;
   endtask

   task automatic test_reset();
      sb.push_back(pack(1'b0, 1'b0, 16'h0000, 16'h0001, NOP));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
      tick(); tick();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         sb.push_back(pack(1'b1, 1'b0, 16'(k), 16'(k + 1), mem(16'(k))));
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL seq_pc%0d got=%h exp=%h", k, obs, e); end
      end
   endtask

   task automatic test_btb_hit();
      train(16'h0005, 16'h0020, 1'b1);
      sb.push_back(pack(1'b1, 1'b0, 16'h0004, 16'h0005, mem(16'h0004)));
      sb.push_back(pack(1'b1, 1'b1, 16'h0005, 16'h0020, mem(16'h0005)));
      sb.push_back(pack(1'b1, 1'b0, 16'h0020, 16'h0021, mem(16'h0020)));
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL btb_hit[%0d] got=%h exp=%h", k, obs, e); end
      end
   endtask

   task automatic test_stall_redirect();
      stall_IF = 1'b1; redirect_EX = 1'b1; redirect_pc_EX = 16'h0040;
      sb.push_back(pack(1'b1, 1'b0, 16'h0020, 16'h0021, mem(16'h0020)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL redir_pre got=%h exp=%h", obs, e); end
      tick();
      redirect_EX = 1'b0;
      sb.push_back(pack(1'b1, 1'b0, 16'h0040, 16'h0041, mem(16'h0040)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL redir_over_stall got=%h exp=%h", obs, e); end
      tick();
      stall_IF = 1'b0;
      sb.push_back(pack(1'b1, 1'b0, 16'h0040, 16'h0041, mem(16'h0040)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL stall_hold got=%h exp=%h", obs, e); end
      tick();
      sb.push_back(pack(1'b1, 1'b0, 16'h0041, 16'h0042, mem(16'h0041)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL stall_release got=%h exp=%h", obs, e); end
   endtask

   task automatic test_not_ready();
      redirect_to(16'h0007);
      i_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         sb.push_back(pack(1'b1, 1'b0, 16'h0007, 16'h0007, NOP));
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL not_ready[%0d] got=%h exp=%h", k, obs, e); end
      end
      i_ready = 1'b1;
      sb.push_back(pack(1'b1, 1'b0, 16'h0007, 16'h0008, mem(16'h0007)));
      sb.push_back(pack(1'b1, 1'b0, 16'h0008, 16'h0009, mem(16'h0008)));
      for (int k = 0; k < 2; k++) begin
         if (k > 0) tick();
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL resume[%0d] got=%h exp=%h", k, obs, e); end
      end
   endtask

   task automatic test_alias_counter();
      logic        tk   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] tgt  [7] = '{16'h0050, 16'h0099, 16'h0099, 16'h0099, 16'h0099, 16'h0060, 16'h0060};
      logic [15:0] post [7] = '{16'h0050, 16'h0050, 16'h0016, 16'h0016, 16'h0016, 16'h0016, 16'h0060};
      logic [15:0] pre;
      train(16'h0015, 16'h0050, 1'b1);
      redirect_to(16'h0005);
      sb.push_back(pack(1'b1, 1'b0, 16'h0005, 16'h0006, mem(16'h0005)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL alias_miss got=%h exp=%h", obs, e); end
      redirect_to(16'h0015);
      sb.push_back(pack(1'b1, 1'b1, 16'h0015, 16'h0050, mem(16'h0015)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL alias_hit got=%h exp=%h", obs, e); end
      // PC parked at 0x15 by stall while the counter is walked
      stall_IF = 1'b1;
      pre = 16'h0050;
      for (int k = 0; k < 7; k++) begin
         btb_update_EX = 1'b1; btb_update_pc_EX = 16'h0015;
         btb_update_target_EX = tgt[k]; btb_update_taken_EX = tk[k];
         sb.push_back(pack(1'b1, 1'b1, 16'h0015, pre, mem(16'h0015)));
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL ctr_pre[%0d] got=%h exp=%h", k, obs, e); end
         tick();
         btb_update_EX = 1'b0;
         sb.push_back(pack(1'b1, 1'b1, 16'h0015, post[k], mem(16'h0015)));
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL ctr_post[%0d] got=%h exp=%h", k, obs, e); end
         pre = post[k];
      end
      stall_IF = 1'b0;
   endtask

   task automatic test_reset_midrun();
      logic [15:0] pcs  [4] = '{16'h0033, 16'h0044, 16'hFFFF, 16'h0000};
      logic [15:0] pred [4] = '{16'h0034, 16'h0045, 16'h0000, 16'h0001};
      train(16'h0033, 16'h0070, 1'b1);
      redirect_to(16'h0033);
      sb.push_back(pack(1'b1, 1'b1, 16'h0033, 16'h0070, mem(16'h0033)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL pre_reset_hit got=%h exp=%h", obs, e); end
      btb_update_EX = 1'b1; btb_update_pc_EX = 16'h0044;
      btb_update_target_EX = 16'h0080; btb_update_taken_EX = 1'b1;
      reset_n = 1'b0;
      sb.push_back(pack(1'b0, 1'b0, 16'h0000, 16'h0001, NOP));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
      tick();
      btb_update_EX = 1'b0;
      reset_n = 1'b1;
      sb.push_back(pack(1'b1, 1'b0, 16'h0000, 16'h0001, mem(16'h0000)));
      #1 e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL post_reset got=%h exp=%h", obs, e); end
      for (int k = 0; k < 4; k++) begin
         if (k < 3) redirect_to(pcs[k]);
         else tick();
         sb.push_back(pack(1'b1, 1'b0, pcs[k], pred[k], mem(pcs[k])));
         #1 e = sb.pop_front(); n_cmp++;
         if (obs !== e) begin n_bad++; $display("FAIL post_reset_miss[%0d] got=%h exp=%h", k, obs, e); end
      end
   endtask

   initial begin
      reset_n = 1'b0; i_ready = 1'b1; stall_IF = 1'b0; redirect_EX = 1'b0;
      redirect_pc_EX = '0; btb_update_EX = 1'b0; btb_update_pc_EX = '0;
      btb_update_target_EX = '0; btb_update_taken_EX = 1'b0;
      test_reset();
      test_btb_hit();
      test_stall_redirect();
      test_not_ready();
      test_alias_counter();
      test_reset_midrun();
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
